// File: rtl/instr_buffer_pkg.sv
// Shared fetch/buffer/decode definitions for the instruction buffer.
// Fetch, the buffer and decode all use this one struct definition.
package instr_buffer_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        excp;
    logic [15:0] excp_num;
  } instr_buffer_info_t;

  localparam int IB_INFO_W = $bits(instr_buffer_info_t);

endpackage

// File: rtl/instr_buffer.sv
// Instruction buffer: circular FIFO between fetch and decode/dispatch.
// It accepts up to IF_WIDTH fetched instructions per cycle and presents
// the oldest DECODE_WIDTH entries, with slot 0 being the oldest.
// Entries retire in order according to the backend's per-slot accept
// mask, so a partial issue of slot 0 alone is absorbed without stalling
// fetch.
module instr_buffer
  import instr_buffer_pkg::*;
#(
  parameter int IF_WIDTH     = 2,
  parameter int DECODE_WIDTH = 2,
  parameter int BUFFER_SIZE  = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  instr_buffer_info_t [IF_WIDTH-1:0]     frontend_instr_i,
  output logic                                  frontend_stallreq_o,
  input  logic [DECODE_WIDTH-1:0]               backend_accept_i,
  output instr_buffer_info_t [DECODE_WIDTH-1:0] backend_instr_o,
  input  logic                                  flush_i,
  input  logic                                  stall_i
);

  localparam int IDX_W = $clog2(BUFFER_SIZE);
  localparam int PTR_W = IDX_W + 1;
  // Stall once a full packet would no longer fit in the free entries.
  localparam logic [PTR_W-1:0] STALL_LIMIT = PTR_W'(BUFFER_SIZE - IF_WIDTH);

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] count;
  logic [PTR_W-1:0] push_cnt;
  logic [PTR_W-1:0] pop_cnt;

  logic [DECODE_WIDTH-1:0] out_valid;
  logic [DECODE_WIDTH-1:0] eff_accept;
  logic                    accept_chain;

  instr_buffer_info_t mem [BUFFER_SIZE];

  assign count = tail - head;

  // Registered count only: there is no combinational path from accept to stall.
  assign frontend_stallreq_o = (count > STALL_LIMIT);

  // Number of entries in the fetch packet. Valid bits form a prefix mask.
  always_comb begin
    push_cnt = '0;
    for (int i = 0; i < IF_WIDTH; i++) begin
      if (frontend_instr_i[i].valid) begin
        push_cnt = push_cnt + PTR_W'(1);
      end
    end
  end

  // In-order retire: a slot retires only if every older slot retires too.
  always_comb begin
    out_valid    = '0;
    eff_accept   = '0;
    pop_cnt      = '0;
    accept_chain = ~stall_i;
    for (int k = 0; k < DECODE_WIDTH; k++) begin
      out_valid[k]  = (count > PTR_W'(k));
      eff_accept[k] = accept_chain & backend_accept_i[k] & out_valid[k];
      accept_chain  = eff_accept[k];
      if (eff_accept[k]) begin
        pop_cnt = pop_cnt + PTR_W'(1);
      end
    end
  end

  // Present the oldest entries. Invalid slots are forced to all-zero.
  always_comb begin
    for (int k = 0; k < DECODE_WIDTH; k++) begin
      backend_instr_o[k] = '0;
      if (out_valid[k]) begin
        backend_instr_o[k]       = mem[head[IDX_W-1:0] + IDX_W'(k)];
        backend_instr_o[k].valid = 1'b1;
      end
    end
  end

  // Write the accepted fetch packet at the tail. Indices wrap on the low bits.
  always_ff @(posedge clk) begin
    if (!rst && !flush_i && !frontend_stallreq_o) begin
      for (int i = 0; i < IF_WIDTH; i++) begin
        if (frontend_instr_i[i].valid) begin
          mem[tail[IDX_W-1:0] + IDX_W'(i)] <= frontend_instr_i[i];
        end
      end
    end
  end

  // Pointer update: reset over flush over normal push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
    end else if (flush_i) begin
      head <= '0;
      tail <= '0;
    end else begin
      head <= head + pop_cnt;
      if (!frontend_stallreq_o) begin
        tail <= tail + push_cnt;
      end
    end
  end

endmodule

// File: tb/tb_instr_buffer.sv
// Self-checking bench for instr_buffer: directed scenarios plus random traffic.
// A queue-based reference model predicts the outputs after each edge. The
// predictions go into a scoreboard that an independent monitor drains.
module tb_instr_buffer;
  import instr_buffer_pkg::*;

  localparam int IFW   = 2;
  localparam int DCW   = 2;
  localparam int BSIZE = 8;

  logic clk;
  logic rst;
  logic flush_i;
  logic stall_i;
  logic [DCW-1:0] backend_accept_i;
  instr_buffer_info_t [IFW-1:0] frontend_instr_i;
  instr_buffer_info_t [DCW-1:0] backend_instr_o;
  logic frontend_stallreq_o;

  instr_buffer #(.IF_WIDTH(IFW), .DECODE_WIDTH(DCW), .BUFFER_SIZE(BSIZE)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .frontend_instr_i    (frontend_instr_i),
    .frontend_stallreq_o (frontend_stallreq_o),
    .backend_accept_i    (backend_accept_i),
    .backend_instr_o     (backend_instr_o),
    .flush_i             (flush_i),
    .stall_i             (stall_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    instr_buffer_info_t s0;
    instr_buffer_info_t s1;
    logic               stq;
  } exp_t;

  instr_buffer_info_t mq[$];
  exp_t exp_q[$];
  int n_checks = 0;
  int n_fails  = 0;

  // Build a fetch entry whose payload is derived from its pc, so a held
  // packet is re-presented identically.
  function automatic instr_buffer_info_t mk_entry(input logic [31:0] pc);
    instr_buffer_info_t e;
    e.valid       = 1'b1;
    e.pc          = pc;
    e.instruction = pc ^ 32'h5a5a_0013;
    e.excp        = pc[3];
    e.excp_num    = pc[19:4];
    return e;
  endfunction

  // Reference model: the buffer is a queue of entries, oldest first.
  task automatic model_step();
    bit stq_pre;
    int n;
    exp_t e;
    stq_pre = (mq.size() > BSIZE - IFW);
    if (rst || flush_i) begin
      mq.delete();
    end else begin
      n = 0;
      if (!stall_i && backend_accept_i[0] && mq.size() > 0) begin
        n = 1;
        if (backend_accept_i[1] && mq.size() > 1) n = 2;
      end
      repeat (n) void'(mq.pop_front());
      if (!stq_pre) begin
        for (int i = 0; i < IFW; i++) begin
          if (frontend_instr_i[i].valid) mq.push_back(frontend_instr_i[i]);
        end
      end
    end
    e.s0  = (mq.size() > 0) ? mq[0] : '0;
    e.s1  = (mq.size() > 1) ? mq[1] : '0;
    e.stq = (mq.size() > BSIZE - IFW);
    exp_q.push_back(e);
  endtask

  // Drive one cycle at the falling edge, then advance the model at the rising edge.
  task automatic cycle(input logic r, input logic fl, input logic st,
                       input logic [1:0] acc, input logic [1:0] vmask,
                       input logic [31:0] pc0);
    @(negedge clk);
    if (vmask == 2'b10) begin
      n_fails++;
      $display("FAIL illegal_valid_mask got=%b required=prefix", vmask);
    end
    rst              = r;
    flush_i          = fl;
    stall_i          = st;
    backend_accept_i = acc;
    for (int i = 0; i < IFW; i++) begin
      frontend_instr_i[i] = '0;
      if (vmask[i]) frontend_instr_i[i] = mk_entry(pc0 + 32'(4 * i));
    end
    @(posedge clk);
    model_step();
  endtask

  task automatic chk(input string name, input logic [IB_INFO_W-1:0] got,
                     input logic [IB_INFO_W-1:0] req);
    n_checks++;
    if (got !== req) begin
      n_fails++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  // Monitor: compare the DUT against each prediction shortly after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("slot0", backend_instr_o[0], e.s0);
        chk("slot1", backend_instr_o[1], e.s1);
        n_checks++;
        if (frontend_stallreq_o !== e.stq) begin
          n_fails++;
          $display("FAIL stallreq got=%b required=%b", frontend_stallreq_o, e.stq);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  vm;
    logic [31:0] pc;
    int          budget;
    rst = 1'b1;
    flush_i = 1'b0;
    stall_i = 1'b0;
    backend_accept_i = '0;
    frontend_instr_i = '0;

    // Reset and empty
    cycle(1, 0, 0, 2'b00, 2'b00, 0);
    cycle(1, 0, 0, 2'b00, 2'b00, 0);
    cycle(0, 0, 0, 2'b00, 2'b00, 0);

    // Basic flow
    cycle(0, 0, 0, 2'b00, 2'b11, 32'h1c00_0000);
    cycle(0, 0, 0, 2'b11, 2'b00, 0);
    cycle(0, 0, 0, 2'b00, 2'b00, 0);

    // Partial issue
    cycle(0, 0, 0, 2'b00, 2'b11, 32'h100);
    cycle(0, 0, 0, 2'b00, 2'b01, 32'h108);
    cycle(0, 0, 0, 2'b01, 2'b00, 0);
    cycle(0, 0, 0, 2'b11, 2'b00, 0);
    cycle(0, 0, 0, 2'b00, 2'b00, 0);

    // Full and backpressure, stall with accept 11, accept 10
    for (int p = 0; p < 4; p++) cycle(0, 0, 0, 2'b00, 2'b11, 32'h300 + 32'(8 * p));
    cycle(0, 0, 0, 2'b00, 2'b11, 32'h380);
    cycle(0, 0, 1, 2'b11, 2'b11, 32'h380);
    cycle(0, 0, 0, 2'b10, 2'b00, 0);
    cycle(0, 0, 0, 2'b11, 2'b00, 0);
    for (int p = 0; p < 3; p++) cycle(0, 0, 0, 2'b11, 2'b00, 0);

    // Wrap: walk head = tail = 7, then straddle the end of storage
    cycle(1, 0, 0, 2'b00, 2'b00, 0);
    cycle(0, 0, 0, 2'b00, 2'b01, 32'h1000);
    for (int p = 1; p < 7; p++) cycle(0, 0, 0, 2'b01, 2'b01, 32'h1000 + 32'(4 * p));
    cycle(0, 0, 0, 2'b01, 2'b00, 0);
    cycle(0, 0, 0, 2'b00, 2'b11, 32'h200);
    cycle(0, 0, 0, 2'b11, 2'b11, 32'h208);
    cycle(0, 0, 0, 2'b00, 2'b00, 0);

    // Flush mid-operation, then flush together with reset
    cycle(0, 0, 0, 2'b00, 2'b11, 32'h500);
    cycle(0, 0, 0, 2'b00, 2'b01, 32'h510);
    cycle(0, 0, 1, 2'b11, 2'b11, 32'h520);
    cycle(0, 1, 0, 2'b11, 2'b11, 32'h530);
    cycle(0, 0, 0, 2'b00, 2'b11, 32'h400);
    cycle(0, 0, 0, 2'b00, 2'b00, 0);
    cycle(1, 1, 0, 2'b11, 2'b11, 32'h600);
    cycle(0, 0, 0, 2'b00, 2'b00, 0);

    // Random traffic; fetch holds its packet while stalled
    vm = 2'b11;
    pc = 32'h2000;
    for (int c = 0; c < 3000; c++) begin
      if (mq.size() <= BSIZE - IFW) begin
        case ($urandom_range(0, 3))
          0:       vm = 2'b00;
          1:       vm = 2'b01;
          default: vm = 2'b11;
        endcase
        pc = $urandom & 32'hffff_fffc;
      end
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), vm, pc);
    end
    cycle(0, 0, 0, 2'b00, 2'b00, 0);

    budget = 10;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      #2;
      budget--;
    end
    if (exp_q.size() > 0) begin
      n_fails++;
      $display("FAIL scoreboard_drain got=%0d required=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
